// File: rtl/goldschmidt_operand_normalizer.sv
// goldschmidt_operand_normalizer
// Front end of the Goldschmidt divider. Each raw unsigned operand is shifted
// left until its MSB is set, so the divider sees 0.WIDTH fractions in
// [0.5,1). The binary scale of the true quotient is reported as
// shift_diff = sb - sa, meaning quotient = q_frac * 2^shift_diff.
// Optional feature macro: DIVZERO_CHECK_EN adds the div_zero output and
// suppresses the divider start when the divisor is zero.
module goldschmidt_operand_normalizer #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_busy,
  output logic [WIDTH-1:0] a_norm,
  output logic [WIDTH-1:0] b_norm,
  output logic             start,
  output logic [CW:0]      shift_diff
`ifdef DIVZERO_CHECK_EN
  ,
  output logic             div_zero
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  // Largest shift count; an operand that reaches it stops shifting.
  localparam logic [CW-1:0] CAP = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    sa;
  logic [CW-1:0]    sb;

  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic [CW-1:0]    sa_next;
  logic [CW-1:0]    sb_next;
  logic             a_done;
  logic             b_done;
  logic             both_done_next;
  logic             zero_abort;

  // An operand is finished once it is normalized, has hit the count cap,
  // or is zero (zero can never be normalized, so its count stays 0).
  function automatic logic op_done(input logic [WIDTH-1:0] v, input logic [CW-1:0] c);
    op_done = v[WIDTH-1] || (c == CAP) || (v == '0);
  endfunction

  // One normalization step per operand, plus the exit test on the
  // post-step values so NORM lasts exactly max(1, lz_a, lz_b) cycles.
  always_comb begin
    a_done         = op_done(a_sh, sa);
    b_done         = op_done(b_sh, sb);
    a_next         = a_done ? a_sh : {a_sh[WIDTH-2:0], 1'b0};
    b_next         = b_done ? b_sh : {b_sh[WIDTH-2:0], 1'b0};
    sa_next        = a_done ? sa : sa + 1'b1;
    sb_next        = b_done ? sb : sb + 1'b1;
    both_done_next = op_done(a_next, sa_next) && op_done(b_next, sb_next);
  end

`ifdef DIVZERO_CHECK_EN
  // A zero divisor stays zero in the shifter, so checking it in NORM
  // catches it on the first NORM cycle.
  assign zero_abort = (b_sh == '0);
`else
  assign zero_abort = 1'b0;
`endif

  assign in_ready = (state == IDLE);
  assign start    = (state == ISSUE) && !div_busy;

  // Control FSM, normalization shifters and the held result registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      sa         <= '0;
      sb         <= '0;
      a_norm     <= '0;
      b_norm     <= '0;
      shift_diff <= '0;
`ifdef DIVZERO_CHECK_EN
      div_zero   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            sa    <= '0;
            sb    <= '0;
            state <= NORM;
`ifdef DIVZERO_CHECK_EN
            div_zero <= 1'b0;
`endif
          end
        end
        NORM: begin
          if (zero_abort) begin
            state <= IDLE;
`ifdef DIVZERO_CHECK_EN
            div_zero <= 1'b1;
`endif
          end else begin
            a_sh <= a_next;
            b_sh <= b_next;
            sa   <= sa_next;
            sb   <= sb_next;
            if (both_done_next) begin
              a_norm     <= a_next;
              b_norm     <= b_next;
              shift_diff <= {1'b0, sb_next} - {1'b0, sa_next};
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!div_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_goldschmidt_operand_normalizer.sv
// tb_goldschmidt_operand_normalizer
// Checks the normalizer against a reference that computes leading-zero
// counts arithmetically and predicts the start cycle from them.
// Honours DIVZERO_CHECK_EN the same way the design does.
module tb_goldschmidt_operand_normalizer;

  logic        clk;
  logic        clrn;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        in_valid;
  logic        in_ready;
  logic        div_busy;
  logic [31:0] a_norm;
  logic [31:0] b_norm;
  logic        start;
  logic [5:0]  shift_diff;
`ifdef DIVZERO_CHECK_EN
  logic        div_zero;
`endif

  int tests_run;
  int tests_failed;

  goldschmidt_operand_normalizer #(.WIDTH(32)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .a_in       (a_in),
    .b_in       (b_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .div_busy   (div_busy),
    .a_norm     (a_norm),
    .b_norm     (b_norm),
    .start      (start),
    .shift_diff (shift_diff)
`ifdef DIVZERO_CHECK_EN
    ,
    .div_zero   (div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference: leading zeros of a nonzero word, zero for a zero word.
  function automatic int ref_lz(input logic [31:0] v);
    int n;
    if (v == 0) return 0;
    n = 0;
    while (v < 32'h8000_0000) begin
      v = v * 2;
      n++;
    end
    return n;
  endfunction

  // One transaction: present a pair, stall the divider for 'busy' cycles of
  // ISSUE, and check timing, pulse width and the normalized results.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int busy);
    int lza, lzb, norm_cycles, exp_start, seen, pulses;
    logic [31:0] exp_a, exp_b;
    logic [5:0]  exp_d;
    bit zero_path;
    lza = ref_lz(a);
    lzb = ref_lz(b);
    norm_cycles = 1;
    if (lza > norm_cycles) norm_cycles = lza;
    if (lzb > norm_cycles) norm_cycles = lzb;
    exp_a = a << lza;
    exp_b = b << lzb;
    exp_d = 6'(lzb - lza);
    exp_start = norm_cycles + 1 + busy;
    zero_path = 1'b0;
`ifdef DIVZERO_CHECK_EN
    zero_path = (b == 0);
`endif
    seen = -1;
    pulses = 0;
    @(negedge clk);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    div_busy = 1'b0;
    #1;
    checkOutput("ready_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      div_busy = (busy > 0) && (n <= norm_cycles + busy);
      #1;
      if (n == 1) checkOutput("ready_busy", {31'b0, in_ready}, 32'd0);
      if (start) begin
        pulses++;
        if (seen < 0) begin
          seen = n;
          checkOutput("a_norm", a_norm, exp_a);
          checkOutput("b_norm", b_norm, exp_b);
          checkOutput("shift_diff", {26'b0, shift_diff}, {26'b0, exp_d});
        end
      end
      if (zero_path && n == 2) begin
`ifdef DIVZERO_CHECK_EN
        checkOutput("div_zero", {31'b0, div_zero}, 32'd1);
`endif
        checkOutput("zero_ready", {31'b0, in_ready}, 32'd1);
        break;
      end
      if (seen >= 0 && n == seen + 1) begin
        checkOutput("ready_after", {31'b0, in_ready}, 32'd1);
        break;
      end
    end
    div_busy = 1'b0;
    if (zero_path) begin
      checkOutput("zero_pulses", 32'(pulses), 32'd0);
    end else begin
      checkOutput("start_cycle", 32'(seen), 32'(exp_start));
      checkOutput("pulse_count", 32'(pulses), 32'd1);
    end
  endtask

  initial begin
    int pulses, first, second, sh;
    logic [31:0] ra, rb;
    tests_run = 0;
    tests_failed = 0;
    clrn = 1'b0;
    a_in = '0;
    b_in = '0;
    in_valid = 1'b0;
    div_busy = 1'b0;

    // Reset values.
    @(negedge clk);
    #1;
    checkOutput("rst_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_start", {31'b0, start}, 32'd0);
    checkOutput("rst_a_norm", a_norm, 32'd0);
    checkOutput("rst_b_norm", b_norm, 32'd0);
    checkOutput("rst_shift", {26'b0, shift_diff}, 32'd0);
`ifdef DIVZERO_CHECK_EN
    checkOutput("rst_div_zero", {31'b0, div_zero}, 32'd0);
`endif
    @(negedge clk);
    clrn = 1'b1;

    // Directed cases.
    applyStimulus(32'hC000_0000, 32'h8000_0000, 0);
    applyStimulus(32'd3, 32'd1, 0);
    applyStimulus(32'h8000_0000, 32'd3, 5);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus(32'd1, 32'hFFFF_FFFF, 2);
    applyStimulus(32'd0, 32'h0001_0000, 0);
    applyStimulus(32'h0000_0123, 32'd0, 0);
    applyStimulus(32'd7, 32'h0000_0040, 0);

    // Randomized pairs with varied magnitudes and divider stalls.
    for (int i = 0; i < 25; i++) begin
      sh = $urandom_range(0, 31);
      ra = $urandom >> sh;
      sh = $urandom_range(0, 31);
      rb = $urandom >> sh;
      if ($urandom_range(0, 9) == 0) ra = 0;
      if ($urandom_range(0, 9) == 0) rb = 0;
      applyStimulus(ra, rb, $urandom_range(0, 3));
    end

    // Reset in the middle of NORM aborts the operation.
    @(negedge clk);
    a_in = 32'd1;
    b_in = 32'd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    clrn = 1'b0;
    #1;
    checkOutput("abort_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("abort_start", {31'b0, start}, 32'd0);
    checkOutput("abort_a_norm", a_norm, 32'd0);
    checkOutput("abort_b_norm", b_norm, 32'd0);
    checkOutput("abort_shift", {26'b0, shift_diff}, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (start) pulses++;
    end
    checkOutput("abort_pulses", 32'(pulses), 32'd0);

    // Back-to-back: in_valid held high across two MSB-set pairs.
    @(negedge clk);
    a_in = 32'h8000_0001;
    b_in = 32'hC000_0000;
    in_valid = 1'b1;
    @(posedge clk);
    pulses = 0;
    first = -1;
    second = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a_in = 32'hF000_0000;
        b_in = 32'h9000_0000;
      end
      if (n == 4) in_valid = 1'b0;
      #1;
      if (n == 2) checkOutput("b2b_ready_c2", {31'b0, in_ready}, 32'd0);
      if (n == 3) checkOutput("b2b_ready_c3", {31'b0, in_ready}, 32'd1);
      if (n == 4) checkOutput("b2b_ready_c4", {31'b0, in_ready}, 32'd0);
      if (start) begin
        pulses++;
        if (first < 0) begin
          first = n;
          checkOutput("b2b_a1", a_norm, 32'h8000_0001);
        end else if (second < 0) begin
          second = n;
          checkOutput("b2b_a2", a_norm, 32'hF000_0000);
          checkOutput("b2b_b2", b_norm, 32'h9000_0000);
        end
      end
    end
    checkOutput("b2b_pulses", 32'(pulses), 32'd2);
    checkOutput("b2b_first", 32'(first), 32'd2);
    checkOutput("b2b_gap", 32'(second - first), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
